// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM state codes and datapath selector codes shared by MIPS control blocks
package mips_pkg;
  localparam logic [5:0] OP_R = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010;
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
    S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10
  } state_t;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00;
  localparam logic [1:0] SRCB_4 = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  typedef struct packed {
    logic pc_write;
    logic pc_write_cond;
    logic i_or_d;
    logic mem_read;
    logic mem_write;
    logic ir_write;
    logic mem_to_reg;
    logic reg_dst;
    logic reg_write;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: state (plus mem_ready in FETCH) to datapath control word
module mc_out_decode
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM2;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main controller FSM with memory-ready stalls
module mc_control
  import mips_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic           illegal_op,
  output logic [3:0]     state_o
);
  state_t state;
  ctrl_t ctrl;
  logic is_r, is_lw, is_sw, is_beq, is_j;
  assign is_r = opcode == OPW'(OP_R);
  assign is_lw = opcode == OPW'(OP_LW);
  assign is_sw = opcode == OPW'(OP_SW);
  assign is_beq = opcode == OPW'(OP_BEQ);
  assign is_j = opcode == OPW'(OP_J);
  assign illegal_op = state == S_DECODE && !(is_r || is_lw || is_sw || is_beq || is_j);
  assign state_o = state;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: state <= is_r ? S_EXEC : (is_lw || is_sw) ? S_MEMADR :
                           is_beq ? S_BRANCH : is_j ? S_JUMP : S_FETCH;
        S_MEMADR: state <= is_sw ? S_MEMWR : S_MEMRD;
        S_MEMRD: state <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWR: state <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC: state <= S_ALUWB;
        default: state <= S_FETCH;
      endcase
  mc_out_decode u_dec (
    .state(state),
    .mem_ready(mem_ready),
    .ctrl(ctrl)
  );
  assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
          RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource} = ctrl;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed vector table, reset corner case and random instruction streams
module tb_mc_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic mem_ready = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
  logic RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_o;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mc_control #(.OPW(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state_o(state_o)
  );

  logic [16:0] act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

  function automatic logic legal(logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 || op == 6'b000010;
  endfunction

  // Control word each state must present, straight from the state descriptions.
  function automatic logic [16:0] exp_ctl(int st, logic rdy, logic [5:0] op);
    logic pcw = 0, pcc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, ill = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    case (st)
      1: begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      2: begin sb = 2'b11; ill = !legal(op); end
      3: begin sa = 1; sb = 2'b10; end
      4: begin mr = 1; iod = 1; end
      5: begin rw = 1; m2r = 1; end
      6: begin mw = 1; iod = 1; end
      7: begin sa = 1; ao = 2'b10; end
      8: begin rw = 1; rd = 1; end
      9: begin sa = 1; ao = 2'b01; pcc = 1; ps = 2'b01; end
      10: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
  endfunction

  task automatic check(input string nm, input int st, input logic rdy, input logic [5:0] op);
    tests++;
    if (state_o !== st[3:0]) begin
      fails++;
      $display("FAIL %s state: got %0d want %0d", nm, state_o, st);
    end
    tests++;
    if (act !== exp_ctl(st, rdy, op)) begin
      fails++;
      $display("FAIL %s ctl (state %0d): got %b want %b", nm, st, act, exp_ctl(st, rdy, op));
    end
  endtask

  task automatic run_cycle(input logic [5:0] o, input logic r, input int st, input string nm);
    @(negedge clk);
    opcode = o;
    mem_ready = r;
    #1;
    check(nm, st, r, o);
  endtask

  typedef struct {
    logic [5:0] op;
    logic rdy;
    int st;
  } vec_t;

  typedef struct {
    int st;
    logic rdy;
  } step_t;

  vec_t vecs[$];
  step_t q[$];

  task automatic add(input logic [5:0] o, input logic r, input int st);
    vec_t v;
    v.op = o; v.rdy = r; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic push(input int st, input logic r);
    step_t s;
    s.st = st; s.rdy = r;
    q.push_back(s);
  endtask

  task automatic push_mem(input int st);
    int k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) push(st, 1'b0);
    push(st, 1'b1);
  endtask

  initial begin
    logic [5:0] op;
    int pick;
    #1;
    check("reset", 0, 1'b0, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_idle", 0, 1'b0, 6'd0);

    add(6'h00, 1, 1); add(6'h00, 1, 2); add(6'h00, 1, 7); add(6'h00, 1, 8);
    add(6'h23, 1, 1); add(6'h23, 1, 2); add(6'h23, 1, 3);
    add(6'h23, 0, 4); add(6'h23, 0, 4); add(6'h23, 1, 4); add(6'h23, 1, 5);
    add(6'h2b, 1, 1); add(6'h2b, 1, 2); add(6'h2b, 1, 3); add(6'h2b, 1, 6);
    add(6'h04, 1, 1); add(6'h04, 1, 2); add(6'h04, 1, 9);
    add(6'h02, 1, 1); add(6'h02, 1, 2); add(6'h02, 1, 10);
    add(6'h08, 0, 1); add(6'h08, 0, 1); add(6'h08, 0, 1); add(6'h08, 1, 1);
    add(6'h08, 1, 2); add(6'h08, 1, 1);
    foreach (vecs[i]) run_cycle(vecs[i].op, vecs[i].rdy, vecs[i].st, $sformatf("vec%0d", i));

    run_cycle(6'h23, 1, 2, "rst_lw_dec");
    run_cycle(6'h23, 1, 3, "rst_lw_adr");
    run_cycle(6'h23, 0, 4, "rst_lw_rd");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_memrd", 0, 1'b0, 6'h23);
    tests++;
    if (MemRead !== 1'b0) begin
      fails++;
      $display("FAIL rst_memread: got %b want 0", MemRead);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_release", 0, 1'b0, 6'h23);

    for (int n = 0; n < 200; n++) begin
      pick = $urandom_range(0, 5);
      op = pick == 0 ? 6'h00 : pick == 1 ? 6'h23 : pick == 2 ? 6'h2b : pick == 3 ? 6'h04 : pick == 4 ? 6'h02 : 6'h3f;
      while (pick == 5 && legal(op)) op = 6'($urandom_range(0, 63));
      if (pick == 5 && op == 6'h3f) op = 6'h08;
      q.delete();
      push_mem(1);
      push(2, 1'($urandom_range(0, 1)));
      case (op)
        6'h00: begin push(7, 1'($urandom_range(0, 1))); push(8, 1'($urandom_range(0, 1))); end
        6'h23: begin push(3, 1'($urandom_range(0, 1))); push_mem(4); push(5, 1'($urandom_range(0, 1))); end
        6'h2b: begin push(3, 1'($urandom_range(0, 1))); push_mem(6); end
        6'h04: push(9, 1'($urandom_range(0, 1)));
        6'h02: push(10, 1'($urandom_range(0, 1)));
        default: ;
      endcase
      foreach (q[i])
        run_cycle(q[i].st == 1 ? 6'($urandom_range(0, 63)) : op, q[i].rdy, q[i].st,
                  $sformatf("rnd%0d_op%02h", n, op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
